// File: rtl/risc_arb_pkg.sv
// risc_arb_pkg: shared FSM state, owner encodings and counter width for mem_port_arbiter.
package risc_arb_pkg;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } arb_state_t;
    localparam logic OWN_CORE = 1'b0;
    localparam logic OWN_DBG  = 1'b1;
    localparam int   CNT_W    = 4;
endpackage

// File: rtl/arb_rr_pick.sv
// arb_rr_pick: combinational round-robin pick between core and debug requests.
// With ARB_LOCK_EN a held lock restricts the pick to the locking port.
module arb_rr_pick
    import risc_arb_pkg::*;
(
    input  logic c_req,
    input  logic d_req,
    input  logic last,
`ifdef ARB_LOCK_EN
    input  logic lock_hold,
    input  logic lock_id,
`endif
    output logic grant_valid,
    output logic grant_id
);
    logic w_c;
    logic w_d;
`ifdef ARB_LOCK_EN
    assign w_c = c_req & ~(lock_hold & (lock_id == OWN_DBG));
    assign w_d = d_req & ~(lock_hold & (lock_id == OWN_CORE));
`else
    assign w_c = c_req;
    assign w_d = d_req;
`endif
    assign grant_valid = w_c | w_d;
    assign grant_id    = (w_c & w_d) ? ~last : (w_d ? OWN_DBG : OWN_CORE);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares a fixed-latency single-port memory between core and debug ports.
// Optional bus lock for debug read-modify-write is enabled with ARB_LOCK_EN.
module mem_port_arbiter
    import risc_arb_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_ack,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy,
    output logic              owner
`ifdef ARB_LOCK_EN
    ,
    input  logic              c_lock,
    input  logic              d_lock
`endif
);
    arb_state_t        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_last;
    logic              r_owner;
    logic              r_m_we;
    logic [ADDR_W-1:0] r_m_addr;
    logic [DATA_W-1:0] r_m_wdata;
    logic [DATA_W-1:0] r_c_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              w_grant_valid;
    logic              w_grant_id;

`ifdef ARB_LOCK_EN
    logic r_lock;
    logic w_lock_hold;
    // The lock only holds while the owner keeps its lock line asserted.
    assign w_lock_hold = r_lock & ((r_owner == OWN_DBG) ? d_lock : c_lock);
`endif

    arb_rr_pick u_pick (
        .c_req       (c_req),
        .d_req       (d_req),
        .last        (r_last),
`ifdef ARB_LOCK_EN
        .lock_hold   (w_lock_hold),
        .lock_id     (r_owner),
`endif
        .grant_valid (w_grant_valid),
        .grant_id    (w_grant_id)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_last    <= OWN_DBG;
            r_owner   <= OWN_CORE;
            r_m_we    <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
            r_c_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_grant_valid) begin
                    r_owner   <= w_grant_id;
                    r_last    <= w_grant_id;
                    r_m_we    <= (w_grant_id == OWN_DBG) ? d_we : c_we;
                    r_m_addr  <= (w_grant_id == OWN_DBG) ? d_addr : c_addr;
                    r_m_wdata <= (w_grant_id == OWN_DBG) ? d_wdata : c_wdata;
                    r_state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    r_cnt   <= CNT_W'(MEM_LAT);
                    r_state <= ST_WAIT;
                end
                ST_WAIT: if (r_cnt == CNT_W'(1)) begin
                    if (!r_m_we && r_owner == OWN_CORE) r_c_rdata <= m_rdata;
                    if (!r_m_we && r_owner == OWN_DBG) r_d_rdata <= m_rdata;
                    r_state <= ST_RESP;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef ARB_LOCK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_lock <= 1'b0;
        else if (r_state == ST_RESP) r_lock <= (r_owner == OWN_DBG) ? d_lock : c_lock;
    end
`endif

    assign m_en    = (r_state == ST_ACCESS);
    assign m_we    = r_m_we;
    assign m_addr  = r_m_addr;
    assign m_wdata = r_m_wdata;
    assign busy    = (r_state != ST_IDLE);
    assign owner   = r_owner;
    assign c_ack   = (r_state == ST_RESP) && (r_owner == OWN_CORE);
    assign d_ack   = (r_state == ST_RESP) && (r_owner == OWN_DBG);
    assign c_rdata = r_c_rdata;
    assign d_rdata = r_d_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: two arbiters (MEM_LAT 1 and 4) checked against a transaction-timeline model.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_fail = 0;

    logic        rst_n [2];
    logic        req   [2][2];
    logic        we    [2][2];
    logic        lock  [2][2];
    logic [15:0] addr  [2][2];
    logic [15:0] wdata [2][2];
    logic [15:0] rdata [2][2];
    logic        ack   [2][2];
    logic        m_en  [2];
    logic        m_we  [2];
    logic        busy  [2];
    logic        owner [2];
    logic [15:0] m_addr  [2];
    logic [15:0] m_wdata [2];
    logic [15:0] m_rdata [2];

    int          ack_cyc  [2][$];
    logic        ack_port [2][$];
    int          en_cyc   [2][$];
    logic        en_we    [2][$];
    logic [15:0] en_wd    [2][$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : 4;
        logic [16:0] pipe [16];
        logic [15:0] mem [256];

        mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(L)) u_dut (
            .clk     (clk),
            .rst_n   (rst_n[g]),
            .c_req   (req[g][0]),
            .c_we    (we[g][0]),
            .c_addr  (addr[g][0]),
            .c_wdata (wdata[g][0]),
            .c_ack   (ack[g][0]),
            .c_rdata (rdata[g][0]),
            .d_req   (req[g][1]),
            .d_we    (we[g][1]),
            .d_addr  (addr[g][1]),
            .d_wdata (wdata[g][1]),
            .d_ack   (ack[g][1]),
            .d_rdata (rdata[g][1]),
            .m_en    (m_en[g]),
            .m_we    (m_we[g]),
            .m_addr  (m_addr[g]),
            .m_wdata (m_wdata[g]),
            .m_rdata (m_rdata[g]),
            .busy    (busy[g]),
            .owner   (owner[g])
`ifdef ARB_LOCK_EN
            ,
            .c_lock  (lock[g][0]),
            .d_lock  (lock[g][1])
`endif
        );

        initial begin
            for (int k = 0; k < 16; k++) pipe[k] <= '0;
            for (int k = 0; k < 256; k++) mem[k] <= 16'(k * 3 + 7);
            mem[8'h10] <= 16'hBEEF;
            mem[8'h20] <= 16'hCAFE;
        end

        // Memory: read data appears exactly L cycles after the strobe, garbage otherwise.
        always @(posedge clk) begin
            for (int k = 15; k > 0; k--) pipe[k] <= pipe[k-1];
            pipe[0] <= {m_en[g] && !m_we[g], mem[m_addr[g][7:0]]};
            if (m_en[g] && m_we[g]) mem[m_addr[g][7:0]] <= m_wdata[g];
        end
        assign m_rdata[g] = pipe[L-1][16] ? pipe[L-1][15:0] : 16'hDEAD;

        always @(negedge clk) if (rst_n[g]) begin
            if (ack[g][0] || ack[g][1]) begin
                ack_cyc[g].push_back(cyc);
                ack_port[g].push_back(ack[g][1]);
            end
            if (m_en[g]) begin
                en_cyc[g].push_back(cyc);
                en_we[g].push_back(m_we[g]);
                en_wd[g].push_back(m_wdata[g]);
            end
        end

        // Timeline model: a grant in cycle t0 strobes at t0+1 and acks at t0+L+2.
        int          t0;
        bit          act;
        bit          gid;
        bit          last;
        bit          lk;
        logic [15:0] erd [2];
        logic        ewe;
        logic [15:0] ead;
        logic [15:0] ewd;
        always @(negedge clk) begin
            bit intx;
            bit eack;
            bit qc;
            bit qd;
            if (!rst_n[g]) begin
                act = 1'b0;
                last = 1'b1;
                lk = 1'b0;
                gid = 1'b0;
                erd = '{16'h0, 16'h0};
                chk("rst_m_en", m_en[g], 0);
                chk("rst_m_we", m_we[g], 0);
                chk("rst_m_addr", m_addr[g], 0);
                chk("rst_m_wdata", m_wdata[g], 0);
                chk("rst_busy", busy[g], 0);
                chk("rst_owner", owner[g], 0);
                chk("rst_c_ack", ack[g][0], 0);
                chk("rst_d_ack", ack[g][1], 0);
                chk("rst_c_rdata", rdata[g][0], 0);
                chk("rst_d_rdata", rdata[g][1], 0);
            end else begin
                intx = act && cyc >= t0 + 1 && cyc <= t0 + L + 2;
                eack = intx && cyc == t0 + L + 2;
                if (eack && !ewe) erd[gid] = mem[ead[7:0]];
                chk("m_en", m_en[g], 32'(intx && cyc == t0 + 1));
                if (intx && cyc == t0 + 1) begin
                    chk("m_we", m_we[g], 32'(ewe));
                    chk("m_addr", m_addr[g], 32'(ead));
                    chk("m_wdata", m_wdata[g], 32'(ewd));
                end
                chk("busy", busy[g], 32'(intx));
                chk("c_ack", ack[g][0], 32'(eack && !gid));
                chk("d_ack", ack[g][1], 32'(eack && gid));
                chk("c_rdata", rdata[g][0], 32'(erd[0]));
                chk("d_rdata", rdata[g][1], 32'(erd[1]));
                chk("owner", owner[g], 32'(gid));
                if (eack) lk = lock[g][gid];
                if (!intx) begin
                    qc = req[g][0];
                    qd = req[g][1];
`ifdef ARB_LOCK_EN
                    if (lk && lock[g][gid]) begin
                        if (gid) qc = 1'b0;
                        else qd = 1'b0;
                    end
`endif
                    if (qc || qd) begin
                        gid = (qc && qd) ? !last : qd;
                        last = gid;
                        act = 1'b1;
                        t0 = cyc;
                        ewe = we[g][gid];
                        ead = addr[g][gid];
                        ewd = wdata[g][gid];
                    end
                end
            end
        end
    end

    // Requester: holds req across n back-to-back transactions, bumping fields after each ack.
    task automatic xfer(input int i, input int p, input logic w, input logic [15:0] a,
                        input logic [15:0] d, input int n, output int t_rise, output int t_ack);
        int wt;
        @(posedge clk); #1;
        req[i][p] = 1'b1;
        we[i][p] = w;
        addr[i][p] = a;
        wdata[i][p] = d;
        t_rise = cyc;
        t_ack = 0;
        for (int k = 0; k < n; k++) begin
            wt = 0;
            do begin
                @(negedge clk);
                wt++;
            end while (!ack[i][p] && wt < 60);
            chk("ack_wait", ack[i][p], 1);
            t_ack = cyc;
            @(posedge clk); #1;
            addr[i][p] = a + 16'(k + 1);
            wdata[i][p] = d + 16'(k + 1);
        end
        req[i][p] = 1'b0;
    endtask

    task automatic clear_logs(input int i);
        ack_cyc[i].delete();
        ack_port[i].delete();
        en_cyc[i].delete();
        en_we[i].delete();
        en_wd[i].delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int tr0, ta0, tr1, ta1, tr, ta;
        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 1'b0;
            for (int p = 0; p < 2; p++) begin
                req[i][p] = 1'b0;
                we[i][p] = 1'b0;
                lock[i][p] = 1'b0;
                addr[i][p] = '0;
                wdata[i][p] = '0;
            end
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", busy[0], 0);
        chk("post_rst_owner", owner[0], 0);
        chk("post_rst_m_en", m_en[0], 0);
        chk("post_rst_c_ack", ack[0][0], 0);

        // Lone core read, MEM_LAT=1
        clear_logs(0);
        xfer(0, 0, 1'b0, 16'h0010, 16'h0, 1, tr, ta);
        chk("t1_m_en_cycle", en_cyc[0][0], tr + 1);
        chk("t1_strobes", en_cyc[0].size(), 1);
        chk("t1_ack_cycle", ta, tr + 3);
        chk("t1_c_rdata", rdata[0][0], 16'hBEEF);
        chk("t1_ack_count", ack_cyc[0].size(), 1);
        chk("t1_ack_port", ack_port[0][0], 0);

        // Both from reset: core first, debug write second
        @(posedge clk); #1;
        rst_n[0] = 1'b0;
        @(posedge clk); #1;
        rst_n[0] = 1'b1;
        clear_logs(0);
        fork
            xfer(0, 0, 1'b0, 16'h0001, 16'h0, 1, tr0, ta0);
            xfer(0, 1, 1'b1, 16'h0002, 16'h1234, 1, tr1, ta1);
        join
        chk("t2_first_port", ack_port[0][0], 0);
        chk("t2_second_port", ack_port[0][1], 1);
        chk("t2_ack_spacing", ta1 - ta0, 4);
        chk("t2_second_we", en_we[0][1], 1);
        chk("t2_second_wdata", en_wd[0][1], 16'h1234);
        chk("t2_mem_written", g_dut[0].mem[8'h02], 16'h1234);

        // Both held for 6 transactions: strict alternation
        clear_logs(0);
        fork
            xfer(0, 0, 1'b0, 16'h0040, 16'h0, 3, tr0, ta0);
            xfer(0, 1, 1'b0, 16'h0050, 16'h0, 3, tr1, ta1);
        join
        chk("t3_ack_count", ack_port[0].size(), 6);
        for (int k = 0; k < 6; k++) chk($sformatf("t3_owner_%0d", k), ack_port[0][k], 32'(k % 2));

        // MEM_LAT=4 debug read then write
        clear_logs(1);
        xfer(1, 1, 1'b0, 16'h0020, 16'h0, 1, tr, ta);
        chk("t4_read_latency", ta - tr, 6);
        chk("t4_d_rdata", rdata[1][1], 16'hCAFE);
        xfer(1, 1, 1'b1, 16'h0021, 16'h5555, 1, tr, ta);
        chk("t4_write_latency", ta - tr, 6);
        chk("t4_d_rdata_kept", rdata[1][1], 16'hCAFE);
        chk("t4_mem_written", g_dut[1].mem[8'h21], 16'h5555);

        // Reset pulse during WAIT aborts the access
        clear_logs(1);
        @(posedge clk); #1;
        req[1][0] = 1'b1;
        we[1][0] = 1'b0;
        addr[1][0] = 16'h0020;
        repeat (3) @(posedge clk);
        #3;
        rst_n[1] = 1'b0;
        req[1][0] = 1'b0;
        #1;
        chk("t5_async_busy", busy[1], 0);
        chk("t5_async_d_rdata", rdata[1][1], 0);
        chk("t5_async_c_ack", ack[1][0], 0);
        @(posedge clk); #1;
        rst_n[1] = 1'b1;
        repeat (8) @(negedge clk);
        chk("t5_no_ack", ack_cyc[1].size(), 0);
        xfer(1, 0, 1'b0, 16'h0020, 16'h0, 1, tr, ta);
        chk("t5_next_latency", ta - tr, 6);
        chk("t5_next_c_rdata", rdata[1][0], 16'hCAFE);

`ifdef ARB_LOCK_EN
        // Debug lock keeps the core out across two debug accesses
        clear_logs(0);
        lock[0][1] = 1'b1;
        fork
            begin
                xfer(0, 1, 1'b0, 16'h0010, 16'h0, 2, tr0, ta0);
                lock[0][1] = 1'b0;
            end
            begin
                @(posedge clk);
                xfer(0, 0, 1'b0, 16'h0020, 16'h0, 1, tr1, ta1);
            end
        join
        chk("t6_ack_count", ack_port[0].size(), 3);
        chk("t6_port0", ack_port[0][0], 1);
        chk("t6_port1", ack_port[0][1], 1);
        chk("t6_port2", ack_port[0][2], 0);
`endif

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and access sequencer for the single-port data memory of the 16-bit RISC core. Shares the memory between the core's load/store port (`c_*`) and a debug/program-loader port (`d_*`). It uses round-robin priority and a request/ack handshake. Every access is sequenced through a fixed-latency memory model, so the datapath and the loader never drive the memory directly.

## Interface
Parameters:
- `ADDR_W`, 16: word address width
- `DATA_W`, 16: data width
- `MEM_LAT`, 1: memory read latency in cycles; legal range 1..15

Ports:
- `clk`  in  1  system clock; all state on rising edge
- `rst_n`  in  1  reset; one clock; asynchronous, active-low
- `c_req`  in  1  core access request; held until `c_ack`
- `c_we`  in  1  core write enable (1 = write)
- `c_addr`  in  ADDR_W  core address
- `c_wdata`  in  DATA_W  core write data
- `c_ack`  out  1  one-cycle completion pulse to core
- `c_rdata`  out  DATA_W  core read data, valid with `c_ack`
- `d_req`, `d_we`, `d_addr`, `d_wdata`, `d_ack`, `d_rdata`: debug port, identical semantics
- `m_en`  out  1  memory access strobe, exactly one cycle per transaction
- `m_we`  out  1  memory write enable, qualified by `m_en`
- `m_addr`  out  ADDR_W  memory address
- `m_wdata`  out  DATA_W  memory write data
- `m_rdata`  in  DATA_W  memory read data, valid `MEM_LAT` cycles after `m_en`
- `busy`  out  1  high in every state except IDLE
- `owner`  out  1  current or last grantee; 0 = core, 1 = debug
- `c_lock`, `d_lock`  in  1  bus lock requests; present only with `ARB_LOCK_EN`

## Operation
- FSM states are IDLE, ACCESS, WAIT and RESP.
- **IDLE**
  - No request: stay in IDLE.
  - Any request: pick the grantee, then register `owner` and the grantee's we/addr/wdata into the `m_*` registers. Go to ACCESS.
- **ACCESS**
  - `m_en` is 1 for this cycle only.
  - Load the latency counter with `MEM_LAT`. Go to WAIT.
- **WAIT**
  - Decrement the counter each cycle.
  - In the cycle the counter reaches 1, `m_rdata` is valid. For reads, capture it into the owner's rdata register. Go to RESP.
- **RESP**
  - Assert the owner's ack for one cycle. Go to IDLE.
- **Pick rule:** round-robin on a `last` register. On a tie, the requester that was not granted last wins. A lone requester always wins.
  - `last` resets to debug, so the core wins the first tie.
- **Writes:** writes use identical timing, and the ack still waits `MEM_LAT`. `x_rdata` is unchanged on writes.
- **Non-owner isolation:** the non-owner's ack and rdata are untouched.
- **Requester rule:** fields must be held stable from req rise through the ack cycle.
  - A req still high in the cycle after ack is a new transaction.
  - A req dropped before ack is a protocol violation. The transaction completes anyway.
- **Reset:** all outputs and rdata registers are 0, `owner` = 0, `last` = debug, state = IDLE.
  - Reset mid-transaction aborts it with no ack. A memory write already strobed is not undone.

## Timing
- Request first high in IDLE cycle T: `m_en` at T+1, data captured at T+MEM_LAT+1, ack at T+MEM_LAT+2.
- Peak throughput is one transaction per MEM_LAT+3 cycles.
- Back-to-back with both ports requesting: grants alternate C, D, C, D.
- With MEM_LAT=1, counter load and expiry coincide: WAIT lasts exactly one cycle.
- The requester sees ack in cycle R. It may update fields at the R/R+1 edge, and IDLE samples them in R+1.

## Configuration
- `ARB_LOCK_EN` defined:
  - `c_lock`/`d_lock` exist.
  - If the owner's lock is high in RESP, the next IDLE considers only the owner's req.
  - While the owner's lock stays high with its req low, the arbiter idles and the other port is held off.
  - Lock dropping restores round-robin.
  - The lock is for read-modify-write from the debug port.
- `ARB_LOCK_EN` undefined: the lock ports are absent, and arbitration is pure round-robin.

## Structure
- Package `risc_arb_pkg` holds:
  - the state enum (IDLE/ACCESS/WAIT/RESP)
  - owner encodings `OWN_CORE`=0 and `OWN_DBG`=1
  - the counter width constant (4)
- Sub-module `arb_rr_pick` is combinational. Its inputs are `c_req`, `d_req`, `last`, plus lock qualifiers under the macro. Its outputs are `grant_valid` and `grant_id`.
- Everything else lives in `mem_port_arbiter`.

## Test plan
- MEM_LAT=1, core read addr 0x0010, memory returns 0xBEEF: `m_en` one cycle at T+1; `c_ack`=1 with `c_rdata`=0xBEEF at T+3; `d_ack` stays 0.
- Both ports request from reset (C read 0x0001, D write 0x0002←0x1234): C granted first, D second. `m_we`=1 with `m_wdata`=0x1234 on the second strobe. Acks are 4 cycles apart.
- Both held requesting for 6 transactions: owner sequence is 0,1,0,1,0,1 with no starvation.
- MEM_LAT=4, debug read: ack exactly 6 cycles after req rise. Write: `d_rdata` keeps its previous value.
- `rst_n` pulsed low during WAIT: no ack is issued. All outputs read 0 asynchronously. The next request is served normally.
- With `ARB_LOCK_EN`, `d_lock`=1 across two debug accesses while `c_req`=1: both debug accesses complete before the core is granted.
